// File: rtl/alu_multi_op_core.sv
`default_nettype none
// ============================================================================
// Module   : alu_multi_op_core
// Purpose  : Tagged-command ALU core. Commands enter through an input FIFO,
//            dispatch in order to a single-cycle ALU lane or an iterative
//            shift-add multiplier lane, and completed results are arbitrated
//            (round-robin) into an output FIFO returned with their tag.
// Ports    : clk, rst            - clock, asynchronous active-high reset
//            cmd_valid/cmd_ready - command handshake
//            cmd_op/id/a/b       - opcode, tag, operands
//            res_valid/res_ready - result handshake (head of output FIFO)
//            res_data/carry/err/id - result fields
//            in_level/out_level  - FIFO occupancy
//            busy                - any FIFO or lane occupied
// Revision : 1.0 - initial release
// ============================================================================
module alu_multi_op_core #(
    parameter int DATA_SIZE = 16,
    parameter int ID_SIZE   = 8,
    parameter int IN_DEPTH  = 4,
    parameter int OUT_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic [2:0]                     cmd_op,
    input  logic [ID_SIZE-1:0]             cmd_id,
    input  logic [DATA_SIZE-1:0]           cmd_a,
    input  logic [DATA_SIZE-1:0]           cmd_b,
    output logic                           res_valid,
    input  logic                           res_ready,
    output logic [DATA_SIZE-1:0]           res_data,
    output logic                           res_carry,
    output logic                           res_err,
    output logic [ID_SIZE-1:0]             res_id,
    output logic [$clog2(IN_DEPTH):0]      in_level,
    output logic [$clog2(OUT_DEPTH):0]     out_level,
    output logic                           busy
);

    localparam int c_M      = DATA_SIZE / 2;
    localparam int c_IN_AW  = $clog2(IN_DEPTH);
    localparam int c_OUT_AW = $clog2(OUT_DEPTH);
    localparam int c_CNT_W  = $clog2(c_M + 1);

    localparam logic [2:0] c_OP_ADD = 3'b000;
    localparam logic [2:0] c_OP_SUB = 3'b001;
    localparam logic [2:0] c_OP_MUL = 3'b010;
    localparam logic [2:0] c_OP_AND = 3'b011;
    localparam logic [2:0] c_OP_OR  = 3'b100;
    localparam logic [2:0] c_OP_XOR = 3'b101;

    localparam logic [c_CNT_W-1:0] c_MUL_STEPS = c_CNT_W'(c_M);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

    // ------------------------------------------------------------------------
    // Input FIFO
    // ------------------------------------------------------------------------
    logic [2:0]           r_in_op [IN_DEPTH];
    logic [ID_SIZE-1:0]   r_in_id [IN_DEPTH];
    logic [DATA_SIZE-1:0] r_in_a  [IN_DEPTH];
    logic [DATA_SIZE-1:0] r_in_b  [IN_DEPTH];
    logic [c_IN_AW:0]     r_in_wr;
    logic [c_IN_AW:0]     r_in_rd;
    logic [c_IN_AW:0]     w_in_wr_nxt;
    logic [c_IN_AW:0]     w_in_rd_nxt;
    logic                 w_in_empty;
    logic                 w_in_full_nxt;
    logic                 w_accept;
    logic                 w_dispatch;
    logic                 r_cmd_ready;

    logic [2:0]           w_h_op;
    logic [ID_SIZE-1:0]   w_h_id;
    logic [DATA_SIZE-1:0] w_h_a;
    logic [DATA_SIZE-1:0] w_h_b;
    logic                 w_h_mul;

    // cmd_ready is registered so it is low during reset; it always equals
    // !full because it is computed from the post-edge pointers.
    assign w_accept    = cmd_valid & r_cmd_ready;
    assign w_in_empty  = (r_in_wr == r_in_rd);
    assign w_in_wr_nxt = r_in_wr + {{c_IN_AW{1'b0}}, w_accept};
    assign w_in_rd_nxt = r_in_rd + {{c_IN_AW{1'b0}}, w_dispatch};
    assign w_in_full_nxt = (w_in_wr_nxt[c_IN_AW] != w_in_rd_nxt[c_IN_AW]) &&
                           (w_in_wr_nxt[c_IN_AW-1:0] == w_in_rd_nxt[c_IN_AW-1:0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in_wr     <= '0;
            r_in_rd     <= '0;
            r_cmd_ready <= 1'b0;
        end else begin
            r_in_wr     <= w_in_wr_nxt;
            r_in_rd     <= w_in_rd_nxt;
            r_cmd_ready <= !w_in_full_nxt;
        end
    end

    // Storage needs no reset: entries are only read when the FIFO is non-empty.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_in_op[r_in_wr[c_IN_AW-1:0]] <= cmd_op;
            r_in_id[r_in_wr[c_IN_AW-1:0]] <= cmd_id;
            r_in_a [r_in_wr[c_IN_AW-1:0]] <= cmd_a;
            r_in_b [r_in_wr[c_IN_AW-1:0]] <= cmd_b;
        end
    end

    assign w_h_op  = r_in_op[r_in_rd[c_IN_AW-1:0]];
    assign w_h_id  = r_in_id[r_in_rd[c_IN_AW-1:0]];
    assign w_h_a   = r_in_a [r_in_rd[c_IN_AW-1:0]];
    assign w_h_b   = r_in_b [r_in_rd[c_IN_AW-1:0]];
    assign w_h_mul = (w_h_op == c_OP_MUL);

    // ------------------------------------------------------------------------
    // Output arbitration
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_DONE = 2'b10
    } mul_state_t;

    mul_state_t r_mul_state;
    mul_state_t w_mul_state_nxt;

    logic r_alu_occ;
    logic r_rr_mul;
    logic w_req_alu;
    logic w_req_mul;
    logic w_gnt_alu;
    logic w_gnt_mul;
    logic w_out_full;

    assign w_req_alu = r_alu_occ;
    assign w_req_mul = (r_mul_state == S_DONE);

    always_comb begin
        w_gnt_alu = 1'b0;
        w_gnt_mul = 1'b0;
        if (!w_out_full) begin
            if (w_req_alu && w_req_mul) begin
                w_gnt_mul = r_rr_mul;
                w_gnt_alu = !r_rr_mul;
            end else begin
                w_gnt_alu = w_req_alu;
                w_gnt_mul = w_req_mul;
            end
        end
    end

    // The pointer only moves on contention, so the first contention after
    // reset always favours the multiplier.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_mul <= 1'b1;
        end else if (w_req_alu && w_req_mul && !w_out_full) begin
            r_rr_mul <= !r_rr_mul;
        end
    end

    // ------------------------------------------------------------------------
    // Dispatch: a lane that hands its result over this cycle may be reloaded
    // in the same cycle, which gives back-to-back ALU throughput.
    // ------------------------------------------------------------------------
    logic w_alu_free;
    logic w_mul_free;
    logic w_alu_load;
    logic w_mul_load;

    assign w_alu_free = !r_alu_occ || w_gnt_alu;
    assign w_mul_free = (r_mul_state == S_IDLE) || w_gnt_mul;
    assign w_dispatch = !w_in_empty && (w_h_mul ? w_mul_free : w_alu_free);
    assign w_alu_load = w_dispatch && !w_h_mul;
    assign w_mul_load = w_dispatch && w_h_mul;

    // ------------------------------------------------------------------------
    // ALU lane
    // ------------------------------------------------------------------------
    logic [DATA_SIZE:0]   w_alu_add;
    logic [DATA_SIZE-1:0] w_alu_data;
    logic                 w_alu_carry;
    logic                 w_alu_err;
    logic [DATA_SIZE-1:0] r_alu_data;
    logic                 r_alu_carry;
    logic                 r_alu_err;
    logic [ID_SIZE-1:0]   r_alu_id;

    assign w_alu_add = {1'b0, w_h_a} + {1'b0, w_h_b};

    always_comb begin
        w_alu_data  = '0;
        w_alu_carry = 1'b0;
        w_alu_err   = 1'b0;
        case (w_h_op)
            c_OP_ADD: begin
                w_alu_data  = w_alu_add[DATA_SIZE-1:0];
                w_alu_carry = w_alu_add[DATA_SIZE];
            end
            c_OP_SUB: begin
                w_alu_data  = w_h_a - w_h_b;
                w_alu_carry = (w_h_a < w_h_b);
            end
            c_OP_AND: w_alu_data = w_h_a & w_h_b;
            c_OP_OR:  w_alu_data = w_h_a | w_h_b;
            c_OP_XOR: w_alu_data = w_h_a ^ w_h_b;
            default:  w_alu_err  = 1'b1;  // illegal opcodes (MUL never loads here)
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alu_occ   <= 1'b0;
            r_alu_data  <= '0;
            r_alu_carry <= 1'b0;
            r_alu_err   <= 1'b0;
            r_alu_id    <= '0;
        end else if (w_alu_load) begin
            r_alu_occ   <= 1'b1;
            r_alu_data  <= w_alu_data;
            r_alu_carry <= w_alu_carry;
            r_alu_err   <= w_alu_err;
            r_alu_id    <= w_h_id;
        end else if (w_gnt_alu) begin
            r_alu_occ   <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // MUL lane: shift-add over the low halves, one multiplier bit per cycle
    // ------------------------------------------------------------------------
    logic [c_CNT_W-1:0]   r_mul_cnt;
    logic [DATA_SIZE-1:0] r_mul_acc;
    logic [DATA_SIZE-1:0] r_mul_mcand;
    logic [c_M-1:0]       r_mul_mplier;
    logic [ID_SIZE-1:0]   r_mul_id;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mul_state <= S_IDLE;
        end else begin
            r_mul_state <= w_mul_state_nxt;
        end
    end

    always_comb begin
        w_mul_state_nxt = r_mul_state;
        case (r_mul_state)
            S_IDLE: begin
                if (w_mul_load) begin
                    w_mul_state_nxt = S_CALC;
                end
            end
            S_CALC: begin
                if (r_mul_cnt == c_CNT_ONE) begin
                    w_mul_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (w_gnt_mul) begin
                    w_mul_state_nxt = w_mul_load ? S_CALC : S_IDLE;
                end
            end
            default: w_mul_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mul_cnt    <= '0;
            r_mul_acc    <= '0;
            r_mul_mcand  <= '0;
            r_mul_mplier <= '0;
            r_mul_id     <= '0;
        end else if (w_mul_load) begin
            r_mul_cnt    <= c_MUL_STEPS;
            r_mul_acc    <= '0;
            r_mul_mcand  <= {{(DATA_SIZE - c_M){1'b0}}, w_h_a[c_M-1:0]};
            r_mul_mplier <= w_h_b[c_M-1:0];
            r_mul_id     <= w_h_id;
        end else if (r_mul_state == S_CALC) begin
            if (r_mul_mplier[0]) begin
                r_mul_acc <= r_mul_acc + r_mul_mcand;
            end
            r_mul_mcand  <= {r_mul_mcand[DATA_SIZE-2:0], 1'b0};
            r_mul_mplier <= {1'b0, r_mul_mplier[c_M-1:1]};
            r_mul_cnt    <= r_mul_cnt - c_CNT_ONE;
        end
    end

    // ------------------------------------------------------------------------
    // Output FIFO (storage reset so the result outputs read 0 after reset)
    // ------------------------------------------------------------------------
    logic [DATA_SIZE-1:0] r_out_data  [OUT_DEPTH];
    logic                 r_out_carry [OUT_DEPTH];
    logic                 r_out_err   [OUT_DEPTH];
    logic [ID_SIZE-1:0]   r_out_id    [OUT_DEPTH];
    logic [c_OUT_AW:0]    r_out_wr;
    logic [c_OUT_AW:0]    r_out_rd;
    logic                 w_out_empty;
    logic                 w_out_wr;
    logic                 w_out_rd;

    assign w_out_empty = (r_out_wr == r_out_rd);
    assign w_out_full  = (r_out_wr[c_OUT_AW] != r_out_rd[c_OUT_AW]) &&
                         (r_out_wr[c_OUT_AW-1:0] == r_out_rd[c_OUT_AW-1:0]);
    assign w_out_wr    = w_gnt_alu | w_gnt_mul;
    assign w_out_rd    = !w_out_empty && res_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_wr <= '0;
            r_out_rd <= '0;
            for (int i = 0; i < OUT_DEPTH; i++) begin
                r_out_data[i]  <= '0;
                r_out_carry[i] <= 1'b0;
                r_out_err[i]   <= 1'b0;
                r_out_id[i]    <= '0;
            end
        end else begin
            if (w_out_wr) begin
                r_out_data [r_out_wr[c_OUT_AW-1:0]] <= w_gnt_mul ? r_mul_acc : r_alu_data;
                r_out_carry[r_out_wr[c_OUT_AW-1:0]] <= w_gnt_mul ? 1'b0 : r_alu_carry;
                r_out_err  [r_out_wr[c_OUT_AW-1:0]] <= w_gnt_mul ? 1'b0 : r_alu_err;
                r_out_id   [r_out_wr[c_OUT_AW-1:0]] <= w_gnt_mul ? r_mul_id : r_alu_id;
                r_out_wr <= r_out_wr + {{c_OUT_AW{1'b0}}, 1'b1};
            end
            if (w_out_rd) begin
                r_out_rd <= r_out_rd + {{c_OUT_AW{1'b0}}, 1'b1};
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign cmd_ready = r_cmd_ready;
    assign res_valid = !w_out_empty;
    assign res_data  = r_out_data [r_out_rd[c_OUT_AW-1:0]];
    assign res_carry = r_out_carry[r_out_rd[c_OUT_AW-1:0]];
    assign res_err   = r_out_err  [r_out_rd[c_OUT_AW-1:0]];
    assign res_id    = r_out_id   [r_out_rd[c_OUT_AW-1:0]];
    assign in_level  = r_in_wr - r_in_rd;
    assign out_level = r_out_wr - r_out_rd;
    assign busy      = !w_in_empty || !w_out_empty || r_alu_occ || (r_mul_state != S_IDLE);

endmodule
`default_nettype wire
